// File: rtl/vga_fb_scheduler_if.sv
// Bundles the line-request, writer handshake, RAM port and line buffer port of the
// framebuffer scheduler so they can be passed around as a single connection.
interface vga_fb_scheduler_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 12
);
    logic              line_req;
    logic [9:0]        line_num;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic              lb_wr_en;
    logic [7:0]        lb_wr_addr;
    logic [DATA_W-1:0] lb_wr_data;
    logic              lb_bank;
    logic              fetch_busy;
    logic              fetch_overrun;

    // The scheduler side.
    modport slave (
        input  line_req, line_num, wr_valid, wr_addr, wr_data, ram_rdata,
        output wr_ready, ram_addr, ram_wdata, ram_we,
        output lb_wr_en, lb_wr_addr, lb_wr_data, lb_bank, fetch_busy, fetch_overrun
    );

    // The environment side: video timing, pixel writer, RAM and line buffer.
    modport master (
        output line_req, line_num, wr_valid, wr_addr, wr_data, ram_rdata,
        input  wr_ready, ram_addr, ram_wdata, ram_we,
        input  lb_wr_en, lb_wr_addr, lb_wr_data, lb_bank, fetch_busy, fetch_overrun
    );
endinterface

// File: rtl/vga_fb_scheduler.sv
// Arbitrates the single-port framebuffer RAM between line-buffer prefetch for VGA
// scanout (always first) and a pixel writer that gets every leftover cycle.
module vga_fb_scheduler #(
    parameter int FB_W        = 200,
    parameter int FB_H        = 150,
    parameter int SCALE_SHIFT = 2,
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 12
) (
    input  logic                 MAX10_CLK1_50,
    input  logic                 rst,
    vga_fb_scheduler_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [9:0]        LINE_LIMIT = 10'(FB_H << SCALE_SHIFT);
    localparam logic [ADDR_W-1:0] FB_WORDS   = ADDR_W'(FB_W * FB_H);
    localparam logic [7:0]        LAST_COL   = 8'(FB_W - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] base;
    logic [7:0]        col;
    logic              lb_valid;
    logic [7:0]        lb_col;
    logic              bank;
    logic              overrun;
    logic              accept;
    logic [ADDR_W-1:0] row_ext;
    logic [ADDR_W-1:0] base_calc;

    assign accept  = (state == IDLE) && bus.line_req && (bus.line_num < LINE_LIMIT);
    assign row_ext = ADDR_W'(bus.line_num >> SCALE_SHIFT);

    // row * 200 as shift-add so no multiplier is needed for the row base.
    assign base_calc = (row_ext << 7) + (row_ext << 6) + (row_ext << 3);

    always_ff @(posedge MAX10_CLK1_50) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fetch bookkeeping; lb_valid/lb_col trail the issued address by one cycle
    // to line up with the RAM read latency.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (rst) begin
            base     <= '0;
            col      <= '0;
            bank     <= 1'b0;
            overrun  <= 1'b0;
            lb_valid <= 1'b0;
            lb_col   <= '0;
        end else begin
            lb_valid <= (state == FETCH);
            lb_col   <= col;
            if (accept) begin
                base <= base_calc;
                col  <= '0;
                bank <= ~bank;
            end else if (state == FETCH) begin
                col <= col + 8'd1;
            end
            if (bus.line_req && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    // Next state plus the RAM port mux: fetch owns the port, otherwise the writer.
    always_comb begin
        state_next     = state;
        bus.wr_ready   = (state != FETCH) && !((state == IDLE) && bus.line_req);
        bus.fetch_busy = (state != IDLE);
        bus.ram_addr   = '0;
        bus.ram_wdata  = {DATA_W{1'b0}};
        bus.ram_we     = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (col == LAST_COL) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state == FETCH) begin
            bus.ram_addr = base + ADDR_W'(col);
        end else if (bus.wr_valid && bus.wr_ready) begin
            bus.ram_addr  = bus.wr_addr;
            bus.ram_wdata = bus.wr_data;
            bus.ram_we    = (bus.wr_addr < FB_WORDS);
        end
    end

    assign bus.lb_wr_en      = lb_valid;
    assign bus.lb_wr_addr    = lb_col;
    assign bus.lb_wr_data    = lb_valid ? bus.ram_rdata : {DATA_W{1'b0}};
    assign bus.lb_bank       = bank;
    assign bus.fetch_overrun = overrun;

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Randomized self-checking bench for vga_fb_scheduler with a behavioural RAM and
// an address-level reference model of framebuffer contents and fetch timing.
module tb_vga_fb_scheduler;

    localparam int FB_W     = 200;
    localparam int FB_H     = 150;
    localparam int ADDR_W   = 15;
    localparam int DATA_W   = 12;
    localparam int FB_WORDS = FB_W * FB_H;

    logic MAX10_CLK1_50 = 1'b0;
    logic rst;

    int total = 0;
    int bad   = 0;

    int unsigned seed;
    bit          model_bank;
    bit          model_overrun;
    logic [11:0] ref_mem [0:32767];
    bit          ref_wr  [0:32767];

    logic [11:0] ram_mem [0:32767];
    bit          ram_wr  [0:32767];
    logic [11:0] ram_q;

    always #10 MAX10_CLK1_50 = ~MAX10_CLK1_50;

    vga_fb_scheduler_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

    vga_fb_scheduler #(
        .FB_W(FB_W), .FB_H(FB_H), .SCALE_SHIFT(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .MAX10_CLK1_50(MAX10_CLK1_50),
        .rst(rst),
        .bus(bus)
    );

    // Power-up framebuffer contents: a hash of the address and a per-run seed.
    function automatic logic [11:0] init_pixel(input int a);
        logic [31:0] h;
        h = 32'(a) * 32'h9E3779B1 + seed;
        return h[27:16];
    endfunction

    function automatic logic [11:0] model_pixel(input int a);
        return ref_wr[a] ? ref_mem[a] : init_pixel(a);
    endfunction

    // Single-port RAM with one cycle of read latency.
    always @(posedge MAX10_CLK1_50) begin
        if (bus.ram_we) begin
            ram_mem[bus.ram_addr] <= bus.ram_wdata;
            ram_wr[bus.ram_addr]  <= 1'b1;
        end
        ram_q <= ram_wr[bus.ram_addr] ? ram_mem[bus.ram_addr] : init_pixel(int'(bus.ram_addr));
    end
    assign bus.ram_rdata = ram_q;

    task automatic next_cycle;
        @(posedge MAX10_CLK1_50);
        #1;
    endtask

    task automatic settle;
        @(negedge MAX10_CLK1_50);
    endtask

    task automatic idle_inputs;
        bus.line_req = 1'b0;
        bus.line_num = '0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        settle();
        total++; if (bus.fetch_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.fetch_busy); end
        total++; if (bus.lb_bank !== 1'b0) begin bad++; $display("FAIL reset_bank got=%b want=0", bus.lb_bank); end
        total++; if (bus.fetch_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", bus.fetch_overrun); end
        total++; if (bus.lb_wr_en !== 1'b0) begin bad++; $display("FAIL reset_lb_en got=%b want=0", bus.lb_wr_en); end
        total++; if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL reset_ram_we got=%b want=0", bus.ram_we); end
        total++; if (bus.ram_addr !== 15'd0) begin bad++; $display("FAIL reset_ram_addr got=%0d want=0", bus.ram_addr); end
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b want=1", bus.wr_ready); end
        rst = 1'b0;
        model_bank    = 1'b0;
        model_overrun = 1'b0;
        next_cycle();
    endtask

    task automatic test_idle_writes(input int n);
        logic        v;
        logic [14:0] a;
        logic [11:0] d;
        for (int i = 0; i < n; i++) begin
            v = (i < 4) ? 1'b1 : 1'($urandom_range(0, 1));
            a = (i < 4) ? 15'h0010 : 15'($urandom_range(0, FB_WORDS - 1));
            d = (i < 4) ? 12'hF00 : 12'($urandom);
            bus.wr_valid = v;
            bus.wr_addr  = a;
            bus.wr_data  = d;
            settle();
            total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL idle_wr_ready i=%0d got=%b want=1", i, bus.wr_ready); end
            total++; if (bus.fetch_busy !== 1'b0) begin bad++; $display("FAIL idle_busy i=%0d got=%b want=0", i, bus.fetch_busy); end
            total++; if (bus.lb_bank !== model_bank) begin bad++; $display("FAIL idle_bank i=%0d got=%b want=%b", i, bus.lb_bank, model_bank); end
            total++; if (bus.ram_we !== v) begin bad++; $display("FAIL idle_ram_we i=%0d got=%b want=%b", i, bus.ram_we, v); end
            total++; if (bus.ram_addr !== (v ? a : 15'd0)) begin bad++; $display("FAIL idle_ram_addr i=%0d got=%0d want=%0d", i, bus.ram_addr, v ? a : 15'd0); end
            total++; if (bus.ram_wdata !== (v ? d : 12'd0)) begin bad++; $display("FAIL idle_ram_wdata i=%0d got=%h want=%h", i, bus.ram_wdata, v ? d : 12'd0); end
            if (v) begin
                ref_mem[a] = d;
                ref_wr[a]  = 1'b1;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    // One full row fetch starting at k=0; optionally a writer asserts valid at the
    // same cycle and holds it until the single leftover slot in DRAIN.
    task automatic test_fetch(input logic [9:0] ln, input bit writer_hold);
        int          base;
        logic [14:0] wa;
        logic [11:0] wd;
        bit          done;
        base = int'(ln / 4) * FB_W;
        wa   = 15'($urandom_range(0, FB_WORDS - 1));
        wd   = 12'($urandom);
        done = 1'b0;
        for (int k = 0; k <= 201; k++) begin
            bus.line_req = (k == 0);
            bus.line_num = ln;
            bus.wr_valid = writer_hold && !done;
            bus.wr_addr  = wa;
            bus.wr_data  = wd;
            settle();
            total++; if (bus.fetch_busy !== (k != 0)) begin bad++; $display("FAIL fetch_busy k=%0d got=%b want=%b", k, bus.fetch_busy, k != 0); end
            total++; if (bus.wr_ready !== (k == 201)) begin bad++; $display("FAIL fetch_wr_ready k=%0d got=%b want=%b", k, bus.wr_ready, k == 201); end
            total++; if (bus.lb_bank !== model_bank) begin bad++; $display("FAIL fetch_bank k=%0d got=%b want=%b", k, bus.lb_bank, model_bank); end
            if (k >= 1 && k <= 200) begin
                total++; if (bus.ram_addr !== 15'(base + k - 1) || bus.ram_we !== 1'b0) begin bad++; $display("FAIL fetch_ram k=%0d addr=%0d we=%b want addr=%0d we=0", k, bus.ram_addr, bus.ram_we, base + k - 1); end
            end else if (k == 201 && writer_hold) begin
                total++; if (bus.ram_addr !== wa || bus.ram_we !== 1'b1 || bus.ram_wdata !== wd) begin bad++; $display("FAIL drain_write addr=%0d we=%b data=%h want addr=%0d we=1 data=%h", bus.ram_addr, bus.ram_we, bus.ram_wdata, wa, wd); end
            end else begin
                total++; if (bus.ram_addr !== 15'd0 || bus.ram_we !== 1'b0) begin bad++; $display("FAIL fetch_ram_quiet k=%0d addr=%0d we=%b want addr=0 we=0", k, bus.ram_addr, bus.ram_we); end
            end
            total++; if (bus.lb_wr_en !== (k >= 2)) begin bad++; $display("FAIL fetch_lb_en k=%0d got=%b want=%b", k, bus.lb_wr_en, k >= 2); end
            if (k >= 2) begin
                total++; if (bus.lb_wr_addr !== 8'(k - 2) || bus.lb_wr_data !== model_pixel(base + k - 2)) begin bad++; $display("FAIL fetch_lb k=%0d col=%0d data=%h want col=%0d data=%h", k, bus.lb_wr_addr, bus.lb_wr_data, k - 2, model_pixel(base + k - 2)); end
            end
            if (k == 0) model_bank = ~model_bank;
            if (k == 201 && writer_hold) begin
                ref_mem[wa] = wd;
                ref_wr[wa]  = 1'b1;
                done        = 1'b1;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_out_of_range;
        logic [9:0]  ln;
        logic [14:0] wa;
        logic [11:0] wd;
        ln = 10'($urandom_range(600, 1023));
        wa = 15'($urandom_range(30000, 32767));
        wd = 12'($urandom);
        bus.line_req = 1'b1;
        bus.line_num = ln;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        settle();
        total++; if (bus.wr_ready !== 1'b0) begin bad++; $display("FAIL oor_ready_req got=%b want=0", bus.wr_ready); end
        total++; if (bus.ram_we !== 1'b0) begin bad++; $display("FAIL oor_we_req got=%b want=0", bus.ram_we); end
        next_cycle();
        bus.line_req = 1'b0;
        settle();
        total++; if (bus.fetch_busy !== 1'b0) begin bad++; $display("FAIL oor_busy got=%b want=0", bus.fetch_busy); end
        total++; if (bus.lb_bank !== model_bank) begin bad++; $display("FAIL oor_bank got=%b want=%b", bus.lb_bank, model_bank); end
        total++; if (bus.fetch_overrun !== model_overrun) begin bad++; $display("FAIL oor_overrun got=%b want=%b", bus.fetch_overrun, model_overrun); end
        total++; if (bus.wr_ready !== 1'b1) begin bad++; $display("FAIL oor_ready got=%b want=1", bus.wr_ready); end
        total++; if (bus.ram_addr !== wa || bus.ram_we !== 1'b0) begin bad++; $display("FAIL oor_write addr=%0d we=%b want addr=%0d we=0", bus.ram_addr, bus.ram_we, wa); end
        next_cycle();
        idle_inputs();
        settle();
        total++; if (bus.fetch_busy !== 1'b0 || bus.lb_wr_en !== 1'b0) begin bad++; $display("FAIL oor_after busy=%b lb_en=%b want 0 0", bus.fetch_busy, bus.lb_wr_en); end
        next_cycle();
    endtask

    task automatic test_overrun(input logic [9:0] ln);
        int  base;
        logic exp_ov;
        base = int'(ln / 4) * FB_W;
        for (int k = 0; k <= 204; k++) begin
            bus.line_req = (k == 0 || k == 100 || k == 201);
            bus.line_num = (k == 0) ? ln : 10'($urandom_range(0, 599));
            settle();
            exp_ov = (k >= 101) ? 1'b1 : model_overrun;
            total++; if (bus.fetch_overrun !== exp_ov) begin bad++; $display("FAIL ov_flag k=%0d got=%b want=%b", k, bus.fetch_overrun, exp_ov); end
            total++; if (bus.fetch_busy !== (k >= 1 && k <= 201)) begin bad++; $display("FAIL ov_busy k=%0d got=%b want=%b", k, bus.fetch_busy, k >= 1 && k <= 201); end
            total++; if (bus.lb_bank !== model_bank) begin bad++; $display("FAIL ov_bank k=%0d got=%b want=%b", k, bus.lb_bank, model_bank); end
            if (k >= 1 && k <= 200) begin
                total++; if (bus.ram_addr !== 15'(base + k - 1)) begin bad++; $display("FAIL ov_ram_addr k=%0d got=%0d want=%0d", k, bus.ram_addr, base + k - 1); end
            end
            if (k == 0) model_bank = ~model_bank;
            next_cycle();
        end
        model_overrun = 1'b1;
        idle_inputs();
    endtask

    task automatic test_reset_mid_fetch(input logic [9:0] ln);
        int base;
        base = int'(ln / 4) * FB_W;
        for (int k = 0; k <= 50; k++) begin
            bus.line_req = (k == 0);
            bus.line_num = ln;
            rst = (k == 50);
            settle();
            if (k >= 1) begin
                total++; if (bus.ram_addr !== 15'(base + k - 1)) begin bad++; $display("FAIL rmf_ram_addr k=%0d got=%0d want=%0d", k, bus.ram_addr, base + k - 1); end
            end
            if (k == 0) model_bank = ~model_bank;
            next_cycle();
        end
        rst = 1'b0;
        idle_inputs();
        model_bank    = 1'b0;
        model_overrun = 1'b0;
        for (int k = 51; k <= 53; k++) begin
            settle();
            total++; if (bus.fetch_busy !== 1'b0) begin bad++; $display("FAIL rmf_busy k=%0d got=%b want=0", k, bus.fetch_busy); end
            total++; if (bus.lb_wr_en !== 1'b0) begin bad++; $display("FAIL rmf_lb_en k=%0d got=%b want=0", k, bus.lb_wr_en); end
            total++; if (bus.lb_bank !== 1'b0) begin bad++; $display("FAIL rmf_bank k=%0d got=%b want=0", k, bus.lb_bank); end
            total++; if (bus.fetch_overrun !== 1'b0) begin bad++; $display("FAIL rmf_overrun k=%0d got=%b want=0", k, bus.fetch_overrun); end
            total++; if (bus.ram_addr !== 15'd0 || bus.ram_we !== 1'b0) begin bad++; $display("FAIL rmf_ram k=%0d addr=%0d we=%b want 0 0", k, bus.ram_addr, bus.ram_we); end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back;
        test_fetch(10'($urandom_range(0, 599)), 1'b1);
        test_fetch(10'($urandom_range(0, 599)), 1'b0);
    endtask

    initial begin
        seed = $urandom;
        rst  = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_idle_writes(24);
        test_fetch(10'd5, 1'b0);
        test_fetch(10'($urandom_range(0, 599)), 1'b1);
        test_fetch(10'd599, 1'b0);
        test_out_of_range();
        test_overrun(10'($urandom_range(0, 599)));
        test_reset_mid_fetch(10'($urandom_range(0, 599)));
        test_fetch(10'($urandom_range(0, 599)), 1'b0);
        test_back_to_back();
        test_idle_writes(8);
        test_fetch(10'd0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
